// File: rtl/serial_pair_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : serial_pair_pkg                                               |
// | Brief    : Shared types and constants for the serial pair serializer.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package serial_pair_pkg;

  // Word width used when the instantiating design does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // IDLE: waiting for a pair; SHIFT: a word's bit is on the serial outputs.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_pair_shift_reg.sv
// +--------------------------------------------------------------------------+
// | Module   : serial_pair_shift_reg                                         |
// | Brief    : WIDTH-bit load/shift register with a registered serial bit.   |
// |            The bit presented on a load is the first bit of the word; the |
// |            remaining bits are kept in the store and shifted out after.   |
// |            Macro SERIAL_PAIR_LSB_FIRST_EN selects LSB-first order.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module serial_pair_shift_reg
  import serial_pair_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] word,
  output logic             serial_bit
);

  // Bits of the current word not yet presented on serial_bit.
  logic [WIDTH-1:0] store;

  // Load presents the first bit immediately; shift presents the next one;
  // otherwise the serial bit is forced low so it is 0 while not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      store      <= '0;
      serial_bit <= 1'b0;
    end else if (load) begin
`ifdef SERIAL_PAIR_LSB_FIRST_EN
      serial_bit <= word[0];
      store      <= word >> 1;
`else
      serial_bit <= word[WIDTH-1];
      store      <= word << 1;
`endif
    end else if (shift) begin
`ifdef SERIAL_PAIR_LSB_FIRST_EN
      serial_bit <= store[0];
      store      <= store >> 1;
`else
      serial_bit <= store[WIDTH-1];
      store      <= store << 1;
`endif
    end else begin
      serial_bit <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_pair_serializer.sv
// +--------------------------------------------------------------------------+
// | Module   : serial_pair_serializer                                        |
// | Brief    : Accepts a parallel (A,B) word pair and emits it as two        |
// |            synchronous bit streams with first/last framing, one bit per  |
// |            cycle, back-to-back words without a bubble.                   |
// |            Macro SERIAL_PAIR_LSB_FIRST_EN: emit LSB first (default MSB). |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module serial_pair_serializer
  import serial_pair_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             out_valid,
  output logic             a,
  output logic             b,
  output logic             first,
  output logic             last
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;       // index of the bit currently on a/b
  logic [CNT_W-1:0]  cnt_next;
  logic              accept;
  logic              shift_en;

  assign accept   = in_valid & in_ready;
  assign cnt_next = cnt + CNT_W'(1);
  // Advance the shifters only while more bits of the current word remain.
  assign shift_en = (state == SHIFT) && (cnt != CNT_LAST);

  // FSM, bit counter and registered handshake/framing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      first     <= 1'b0;
      last      <= 1'b0;
      in_ready  <= 1'b1;
    end else if (accept) begin
      // Taken from IDLE or on the last bit: next cycle shows bit 0.
      state     <= SHIFT;
      cnt       <= '0;
      out_valid <= 1'b1;
      first     <= 1'b1;
      last      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          if (cnt == CNT_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            first     <= 1'b0;
            last      <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            cnt      <= cnt_next;
            first    <= 1'b0;
            last     <= (cnt_next == CNT_LAST);
            // Ready opens on the final bit so the next word can follow directly.
            in_ready <= (cnt_next == CNT_LAST);
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          first     <= 1'b0;
          last      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  serial_pair_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_a (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .shift      (shift_en),
    .word       (a_word),
    .serial_bit (a)
  );

  serial_pair_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_b (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .shift      (shift_en),
    .word       (b_word),
    .serial_bit (b)
  );

endmodule

`default_nettype wire

// File: tb/tb_serial_pair_serializer.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_serial_pair_serializer                                     |
// | Brief    : Self-checking bench for serial_pair_serializer (WIDTH=4).     |
// |            Reference model: a queue of expected per-cycle output beats.  |
// |            Honours SERIAL_PAIR_LSB_FIRST_EN for bit order.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_serial_pair_serializer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_word = '0;
  logic [WIDTH-1:0] b_word = '0;
  logic             out_valid;
  logic             a;
  logic             b;
  logic             first;
  logic             last;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic a;
    logic b;
    logic first;
    logic last;
  } beat_t;

  // Expected beats: entry 0 is what the outputs must show in the current cycle.
  beat_t q[$];

  serial_pair_serializer #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .out_valid (out_valid),
    .a         (a),
    .b         (b),
    .first     (first),
    .last      (last)
  );

  always #5 clk = ~clk;

  // i-th transmitted bit of a word.
  function automatic logic bit_at(input logic [WIDTH-1:0] w, input int i);
`ifdef SERIAL_PAIR_LSB_FIRST_EN
    return w[i];
`else
    return w[WIDTH-1-i];
`endif
  endfunction

  function automatic beat_t exp_beat();
    if (q.size() > 0) return q[0];
    return '0;
  endfunction

  function automatic logic exp_valid();
    return q.size() > 0;
  endfunction

  // Ready whenever nothing, or only the final beat, is still pending.
  function automatic logic exp_ready();
    return q.size() <= 1;
  endfunction

  // Advance the model by one clock edge.
  task automatic model_clock(input logic r, input logic acc,
                             input logic [WIDTH-1:0] aw, input logic [WIDTH-1:0] bw);
    if (r) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (acc)
        for (int i = 0; i < WIDTH; i++)
          q.push_back('{a: bit_at(aw, i), b: bit_at(bw, i),
                        first: (i == 0), last: (i == WIDTH - 1)});
    end
  endtask

  task automatic test_reset();
    beat_t e;
    rst = 1'b1; in_valid = 1'b1; a_word = 4'hF; b_word = 4'hF;
    repeat (2) @(posedge clk);
    model_clock(1'b1, 1'b0, '0, '0);
    @(negedge clk);
    in_valid = 1'b0;
    e = exp_beat();
    checks++;
    if ({out_valid, a, b, first, last, in_ready} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
      begin errors++; $display("FAIL reset_state got=%b required=000001",
                               {out_valid, a, b, first, last, in_ready}); end
    rst = 1'b0;
    @(posedge clk);
    model_clock(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    e = exp_beat();
    checks++;
    if ({out_valid, in_ready} !== {exp_valid(), exp_ready()} || e.first !== first)
      begin errors++; $display("FAIL reset_release got v/r=%b%b", out_valid, in_ready); end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] sa, sb;
    logic acc;
    beat_t e;
    sa = '0; sb = '0;
    for (int cyc = 0; cyc <= WIDTH + 1; cyc++) begin
      in_valid = (cyc == 0);
      a_word   = (cyc == 0) ? 4'b1010 : 4'b0101;
      b_word   = (cyc == 0) ? 4'b1001 : 4'b0110;
      #1;
      e = exp_beat();
      checks++;
      if ({out_valid, a, b, first, last, in_ready} !==
          {exp_valid(), e.a, e.b, e.first, e.last, exp_ready()})
        begin errors++; $display("FAIL directed cyc=%0d got=%b required=%b", cyc,
          {out_valid, a, b, first, last, in_ready},
          {exp_valid(), e.a, e.b, e.first, e.last, exp_ready()}); end
      if (cyc >= 1 && cyc <= WIDTH) begin sa = {sa[WIDTH-2:0], a}; sb = {sb[WIDTH-2:0], b}; end
      acc = in_valid && exp_ready();
      @(posedge clk);
      model_clock(1'b0, acc, a_word, b_word);
      @(negedge clk);
    end
    checks++;
`ifdef SERIAL_PAIR_LSB_FIRST_EN
    if (sa !== 4'b0101 || sb !== 4'b1001)
      begin errors++; $display("FAIL directed_stream got a=%b b=%b required a=0101 b=1001", sa, sb); end
`else
    if (sa !== 4'b1010 || sb !== 4'b1001)
      begin errors++; $display("FAIL directed_stream got a=%b b=%b required a=1010 b=1001", sa, sb); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] rv;
    logic [7:0] vv;
    logic acc;
    beat_t e;
    rv = '0; vv = '0;
    for (int cyc = 0; cyc <= 2 * WIDTH + 1; cyc++) begin
      in_valid = (cyc < WIDTH + 1);
      a_word   = (cyc == 0) ? 4'hF : 4'h3;
      b_word   = (cyc == 0) ? 4'h0 : 4'h3;
      #1;
      e = exp_beat();
      checks++;
      if ({out_valid, a, b, first, last, in_ready} !==
          {exp_valid(), e.a, e.b, e.first, e.last, exp_ready()})
        begin errors++; $display("FAIL back_to_back cyc=%0d got=%b required=%b", cyc,
          {out_valid, a, b, first, last, in_ready},
          {exp_valid(), e.a, e.b, e.first, e.last, exp_ready()}); end
      if (cyc <= 7) rv = {rv[6:0], in_ready};
      if (cyc >= 1 && cyc <= 8) vv = {vv[6:0], out_valid};
      acc = in_valid && exp_ready();
      @(posedge clk);
      model_clock(1'b0, acc, a_word, b_word);
      @(negedge clk);
    end
    checks++;
    if (rv !== 8'b1000_1000 || vv !== 8'hFF)
      begin errors++; $display("FAIL back_to_back_ready got ready=%b valid=%b required ready=10001000 valid=11111111", rv, vv); end
  endtask

  task automatic test_reset_mid_word();
    logic acc;
    logic saw_last;
    beat_t e;
    saw_last = 1'b0;
    for (int cyc = 0; cyc <= 9; cyc++) begin
      in_valid = (cyc == 0) || (cyc == 2) || (cyc == 5);
      rst      = (cyc == 2);
      a_word   = 4'($urandom);
      b_word   = 4'($urandom);
      #1;
      e = exp_beat();
      checks++;
      if ({out_valid, a, b, first, last, in_ready} !==
          {exp_valid(), e.a, e.b, e.first, e.last, exp_ready()})
        begin errors++; $display("FAIL reset_mid_word cyc=%0d got=%b required=%b", cyc,
          {out_valid, a, b, first, last, in_ready},
          {exp_valid(), e.a, e.b, e.first, e.last, exp_ready()}); end
      if (cyc >= 3 && cyc <= 5 && (last || out_valid)) saw_last = 1'b1;
      acc = in_valid && exp_ready();
      @(posedge clk);
      model_clock(rst, acc, a_word, b_word);
      @(negedge clk);
    end
    rst = 1'b0;
    checks++;
    if (saw_last !== 1'b0)
      begin errors++; $display("FAIL reset_mid_word_abandon got=1 required=0"); end
  endtask

  task automatic test_random();
    logic acc;
    beat_t e;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      rst      = ($urandom_range(0, 49) == 0);
      a_word   = 4'($urandom);
      b_word   = 4'($urandom);
      #1;
      e = exp_beat();
      checks++;
      if ({out_valid, a, b, first, last, in_ready} !==
          {exp_valid(), e.a, e.b, e.first, e.last, exp_ready()})
        begin errors++; $display("FAIL random cyc=%0d got=%b required=%b", cyc,
          {out_valid, a, b, first, last, in_ready},
          {exp_valid(), e.a, e.b, e.first, e.last, exp_ready()}); end
      acc = in_valid && exp_ready();
      @(posedge clk);
      model_clock(rst, acc, a_word, b_word);
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (WIDTH + 1) begin
      @(posedge clk);
      model_clock(1'b0, 1'b0, '0, '0);
    end
    @(negedge clk);
  endtask

`ifdef SERIAL_PAIR_LSB_FIRST_EN
  task automatic test_bit_order();
    logic [WIDTH-1:0] sa, sb;
    sa = '0; sb = '0;
    in_valid = 1'b1; a_word = 4'b0001; b_word = 4'b1000;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sa = {sa[WIDTH-2:0], a}; sb = {sb[WIDTH-2:0], b};
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (sa !== 4'b1000 || sb !== 4'b0001)
      begin errors++; $display("FAIL lsb_order got a=%b b=%b required a=1000 b=0001", sa, sb); end
  endtask
`else
  // Serial MSB-first comparator driven from the stream, restarted on first.
  task automatic test_compare();
    logic [WIDTH-1:0] pa [3];
    logic [WIDTH-1:0] pb [3];
    int  cs;   // 0 equal, 1 a<b, 2 a>b
    int  want;
    logic done;
    pa[0] = 4'd5; pb[0] = 4'd9;
    pa[1] = 4'd9; pb[1] = 4'd5;
    pa[2] = 4'd7; pb[2] = 4'd7;
    for (int p = 0; p < 3; p++) begin
      in_valid = 1'b1; a_word = pa[p]; b_word = pb[p];
      want = (pa[p] < pb[p]) ? 1 : (pa[p] > pb[p]) ? 2 : 0;
      cs = 0; done = 1'b0;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < WIDTH + 1 && !done; c++) begin
        if (out_valid) begin
          if (first) cs = 0;
          if (cs == 0 && a !== b) cs = a ? 2 : 1;
          if (last) begin
            done = 1'b1;
            checks++;
            if (cs != want)
              begin errors++; $display("FAIL compare pair=%0d got=%0d required=%0d", p, cs, want); end
          end
        end
        @(posedge clk); @(negedge clk);
      end
      if (!done) begin
        errors++; checks++;
        $display("FAIL compare_timeout pair=%0d no last seen", p);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
`ifdef SERIAL_PAIR_LSB_FIRST_EN
    test_bit_order();
`else
    test_compare();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
